// File: rtl/uart_rx_fifo_if.sv
// Receive stream from uart_rx_fifo to its consumer: head-of-FIFO frame plus its error flags.
// One entry leaves on every clk edge where m_valid && m_ready.
interface uart_rx_fifo_if;
    logic [7:0] m_data;
    logic       m_frame_err;
    logic       m_parity_err;
    logic       m_break;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, m_frame_err, m_parity_err, m_break, m_valid, input m_ready);
    modport slave  (input m_data, m_frame_err, m_parity_err, m_break, m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled UART receiver with 3-sample majority vote, feeding a DEPTH-entry frame FIFO.
// Entry lands one clk after the final stop-bit sample; a full FIFO without a pop drops it and pulses overrun.

module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             rx_en,
    input  logic [DIV_W-1:0] div,
    input  logic [3:0]       length,
    input  logic             parity_en,
    input  logic             parity_type,
    input  logic             stop2,
    uart_rx_fifo_if.master   m,
    output logic             overrun,
    output logic             busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t           state;
    logic             rx_s1;
    logic             rx_s2;
    logic [DIV_W-1:0] tick_cnt;
    logic [DIV_W-1:0] div_eff;
    logic             tick;
    logic             mid;
    logic             at_end;
    logic [3:0]       idx;
    logic [3:0]       bit_cnt;
    logic [3:0]       len_l;
    logic             par_en_l;
    logic             par_type_l;
    logic             stop2_l;
    logic             armed;
    logic             smp7;
    logic             smp8;
    logic             maj;
    logic [7:0]       data_sh;
    logic             frame_err;
    logic             parity_err;
    logic             all_zero;
    logic             push_vld;
    logic [10:0]      push_dat;
    logic [10:0]      head_dat;
    logic             fifo_empty;
    logic             fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    assign div_eff = (div == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : div;
    assign tick    = (tick_cnt >= div_eff - 1'b1);
    assign mid     = tick && (idx == 4'd9);
    assign at_end  = tick && (idx == 4'd15);
    // Third vote is the live sample taken on the index-9 tick.
    assign maj     = (smp7 & smp8) | (smp7 & rx_s2) | (smp8 & rx_s2);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            idx        <= '0;
            bit_cnt    <= '0;
            len_l      <= 4'd8;
            par_en_l   <= 1'b0;
            par_type_l <= 1'b0;
            stop2_l    <= 1'b0;
            armed      <= 1'b1;
            smp7       <= 1'b0;
            smp8       <= 1'b0;
            data_sh    <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            all_zero   <= 1'b0;
            push_vld   <= 1'b0;
            push_dat   <= '0;
            overrun    <= 1'b0;
        end else begin
            push_vld <= 1'b0;
            overrun  <= push_vld && fifo_full && !m.m_ready;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                idx <= idx + 1'b1;
                if (idx == 4'd7) smp7 <= rx_s2;
                if (idx == 4'd8) smp8 <= rx_s2;
            end

            case (state)
                S_IDLE: begin
                    if (rx_s2) armed <= 1'b1;
                    if (armed && rx_en && !rx_s2) begin
                        state      <= S_START;
                        armed      <= 1'b0;
                        tick_cnt   <= '0;
                        idx        <= '0;
                        bit_cnt    <= '0;
                        len_l      <= (length >= 4'd5 && length <= 4'd8) ? length : 4'd8;
                        par_en_l   <= parity_en;
                        par_type_l <= parity_type;
                        stop2_l    <= stop2;
                        data_sh    <= '0;
                        frame_err  <= 1'b0;
                        parity_err <= 1'b0;
                        all_zero   <= 1'b1;
                    end
                end
                S_START: begin
                    if (mid && maj)  state <= S_IDLE;
                    else if (at_end) state <= S_DATA;
                end
                S_DATA: begin
                    if (mid) begin
                        data_sh[bit_cnt[2:0]] <= maj;
                        if (maj) all_zero <= 1'b0;
                    end
                    if (at_end) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == len_l - 4'd1) state <= par_en_l ? S_PARITY : S_STOP1;
                    end
                end
                S_PARITY: begin
                    if (mid) begin
                        if (maj != (par_type_l ? ^data_sh : ~^data_sh)) parity_err <= 1'b1;
                        if (maj) all_zero <= 1'b0;
                    end
                    if (at_end) state <= S_STOP1;
                end
                S_STOP1: begin
                    if (mid) begin
                        if (!maj) frame_err <= 1'b1;
                        all_zero <= all_zero && !maj;
                        // Leaving at mid-stop gives half a bit of margin to catch the next start edge.
                        if (!stop2_l) begin
                            push_vld <= 1'b1;
                            push_dat <= {all_zero && !maj, parity_err, frame_err || !maj, data_sh};
                            state    <= S_IDLE;
                        end
                    end
                    if (at_end) state <= S_STOP2;
                end
                S_STOP2: begin
                    if (mid) begin
                        push_vld <= 1'b1;
                        push_dat <= {all_zero, parity_err, frame_err || !maj, data_sh};
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    sync_fifo #(.WIDTH(11), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_vld),
        .push_dat (push_dat),
        .pop      (m.m_ready),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign m.m_valid = !fifo_empty;
    assign {m.m_break, m.m_parity_err, m.m_frame_err, m.m_data} = fifo_empty ? 11'd0 : head_dat;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are driven bit by bit on rx and every popped entry
// {break, parity_err, frame_err, data} is compared with a hand-computed value.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        rx_en = 1'b1;
    logic [15:0] div = 16'd27;
    logic [3:0]  length = 4'd8;
    logic        parity_en = 1'b0;
    logic        parity_type = 1'b0;
    logic        stop2 = 1'b0;
    logic        overrun;
    logic        busy;

    uart_rx_fifo_if m ();

    uart_rx_fifo #(.DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_en       (rx_en),
        .div         (div),
        .length      (length),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop2       (stop2),
        .m           (m),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          ovr_cnt = 0;
    int          vld_cycles = 0;
    logic [10:0] got[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (m.m_valid && m.m_ready) got.push_back({m.m_break, m.m_parity_err, m.m_frame_err, m.m_data});
            if (m.m_valid) vld_cycles++;
            if (overrun) ovr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clk(16 * int'(div));
    endtask

    // One-tick pulse of the opposite level covering only the index-8 sample.
    task automatic send_glitch_bit(input logic b);
        int d;
        d = int'(div);
        rx = b;
        wait_clk(9 * d - 1);
        rx = ~b;
        wait_clk(d);
        rx = b;
        wait_clk(6 * d + 1);
    endtask

    // pbit / s2bit < 0 means that bit is not sent; one idle bit always follows.
    task automatic send_frame(input logic [7:0] d, input int nb, input int pbit, input logic s1, input int s2bit);
        send_bit(1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i]);
        if (pbit >= 0) send_bit(pbit[0]);
        send_bit(s1);
        if (s2bit >= 0) send_bit(s2bit[0]);
        send_bit(1'b1);
    endtask

    task automatic expect_entry(input string tag, input logic [10:0] exp);
        logic [31:0] obs;
        int          n;
        obs = 32'hFFFF_FFFF;
        n = 0;
        while (got.size() == 0 && n < 20000) begin
            wait_clk(1);
            n++;
        end
        if (got.size() > 0) obs = 32'(got.pop_front());
        chk(tag, obs, 32'(exp));
    endtask

    initial begin
        logic [7:0] v;
        int         g;
        m.m_ready = 1'b0;
        wait_clk(3);
        chk("rst_valid", 32'(m.m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_data", 32'(m.m_data), 0);
        rst = 1'b0;
        wait_clk(5);

        // 8N1 at div 27
        m.m_ready = 1'b1;
        send_frame(8'hA5, 8, -1, 1'b1, -1);
        expect_entry("a5", 11'h0A5);
        chk("a5_valid_cycles", 32'(vld_cycles), 1);

        // 5 bits, even parity: 0x13 has three ones so the parity bit is 1
        div = 16'd4;
        length = 4'd5;
        parity_en = 1'b1;
        parity_type = 1'b1;
        wait_clk(10);
        send_frame(8'h13, 5, 1, 1'b1, -1);
        expect_entry("par_ok", 11'h013);
        send_frame(8'h13, 5, 0, 1'b1, -1);
        expect_entry("par_bad", 11'h213);

        // two stop bits, second one low
        length = 4'd8;
        parity_en = 1'b0;
        stop2 = 1'b1;
        send_frame(8'h5A, 8, -1, 1'b1, 0);
        expect_entry("stop2_ferr", 11'h15A);
        send_frame(8'h3C, 8, -1, 1'b1, 1);
        expect_entry("stop2_clean", 11'h03C);

        // line held low for 20 bits
        stop2 = 1'b0;
        rx = 1'b0;
        wait_clk(20 * 16 * int'(div));
        rx = 1'b1;
        wait_clk(2 * 16 * int'(div));
        expect_entry("break", 11'h500);
        wait_clk(32 * int'(div));
        chk("break_single", 32'(got.size()), 0);

        // quarter-bit glitch on an idle line
        rx = 1'b0;
        wait_clk(2 * int'(div));
        chk("glitch_busy", 32'(busy), 1);
        wait_clk(2 * int'(div));
        rx = 1'b1;
        wait_clk(10 * int'(div));
        chk("glitch_idle", 32'(busy), 0);
        wait_clk(32 * int'(div));
        chk("glitch_no_entry", 32'(got.size()), 0);

        // data bit 3 of 0x81 carries a one-tick high pulse at its middle sample
        v = 8'h81;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) send_glitch_bit(v[i]);
            else        send_bit(v[i]);
        end
        send_bit(1'b1);
        send_bit(1'b1);
        expect_entry("data_glitch", 11'h081);

        // fill past DEPTH with no consumer
        m.m_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) send_frame(8'h10 + 8'(i), 8, -1, 1'b1, -1);
        chk("full_no_pop", 32'(got.size()), 0);
        chk("full_overrun", 32'(ovr_cnt), 1);

        // push meets a single-cycle pop while full
        fork
            send_frame(8'h99, 8, -1, 1'b1, -1);
            begin
                g = 0;
                while (!busy && g < 2000) begin wait_clk(1); g++; end
                while (busy && g < 4000) begin wait_clk(1); g++; end
                m.m_ready = 1'b1;
                wait_clk(1);
                m.m_ready = 1'b0;
            end
        join
        m.m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) expect_entry($sformatf("fifo_%0d", i), 11'h010 + 11'(i));
        expect_entry("fifo_coincident", 11'h099);
        chk("coincident_no_overrun", 32'(ovr_cnt), 1);

        // reset in the middle of a frame
        m.m_ready = 1'b0;
        send_frame(8'h42, 8, -1, 1'b1, -1);
        chk("pre_rst_valid", 32'(m.m_valid), 1);
        rx = 1'b0;
        wait_clk(24 * int'(div));
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(m.m_valid), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        wait_clk(3);
        rst = 1'b0;
        rx = 1'b1;
        wait_clk(32 * int'(div));
        m.m_ready = 1'b1;
        wait_clk(2);
        chk("rst_no_entry", 32'(got.size()), 0);
        send_frame(8'h6E, 8, -1, 1'b1, -1);
        expect_entry("post_rst", 11'h06E);
        wait_clk(32 * int'(div));
        chk("post_rst_single", 32'(got.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Single-clock UART receiver, the far end of uart_tx.
- Runs on the system clock and derives its own 16x oversample tick from a programmable divisor; there is no separate rx_clk domain.
- Recovers 5–8 bit frames with optional parity and 1 or 2 stop bits, majority-vote sampled.
- Pushes each frame plus its error flags into a small FIFO, drained by a valid/ready consumer in uart_top.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
DIV_W, 16, width of the oversample divisor input.

Ports:
clk  input  1  system clock.
rst  input  1  reset, asynchronous, active-high.
rx  input  1  serial line, asynchronous to clk, idle high.
rx_en  input  1  enables start-bit detection; a frame already in progress completes.
div  input  DIV_W  clk cycles per oversample tick; 0 is treated as 1 (e.g. 27 gives 115200 baud at 50 MHz).
length  input  4  data bits; 5..8 valid, any other value is treated as 8.
parity_en  input  1  a parity bit follows the data bits.
parity_type  input  1  1 = even parity (expected bit = ^data), 0 = odd (expected bit = ~^data).
stop2  input  1  two stop bits.
m_data  output  8  received data, LSB-aligned, unused upper bits 0.
m_frame_err  output  1  stop bit(s) sampled 0 for this entry.
m_parity_err  output  1  parity mismatch for this entry (always 0 when parity_en was 0).
m_break  output  1  all data bits, parity bit (if any) and first stop bit were 0.
m_valid  output  1  FIFO non-empty.
m_ready  input  1  consumer pop; a pop occurs when m_valid && m_ready.
overrun  output  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
busy  output  1  receiver FSM not in IDLE.

Behaviour:
- Reset values: all outputs 0; synchronizer flops 1; FIFO empty; FSM in IDLE; the IDLE "armed" flag set.
- rx path: 2-flop synchronizer; all references to rx below mean the synchronized value.
- Tick counter: counts 0..max(div,1)-1 and pulses tick for one clk at terminal count.
  - Cleared to 0 on entry to START so bit timing aligns with the falling edge.
- Config (length, parity_en, parity_type, stop2) is latched on START entry; changes mid-frame have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - Each state uses a 4-bit tick index 0..15.
  - Samples are taken at tick indices 7, 8 and 9; the bit value is the majority of the three.
- IDLE:
  - armed is set whenever rx==1.
  - On armed && rx_en && rx==0: go to START, clear armed.
- START: evaluated at tick index 9.
  - Majority 1 is a glitch: return to IDLE, nothing pushed.
  - Majority 0: continue to index 15, then go to DATA.
- DATA: shift bits in LSB-first; after `length` bits go to PARITY if parity_en, else STOP1.
- PARITY: compare the sampled bit with the expected bit computed over the received bits only; a mismatch sets parity_err.
- STOP1:
  - A majority of 0 sets frame_err.
  - If stop2, go to STOP2 at index 15.
  - Otherwise push at index 9 and go to IDLE immediately (half-bit resync margin).
- STOP2: a majority of 0 sets frame_err; push at index 9, go to IDLE.
- Break/framing recovery: after frame_err, armed stays clear until rx is seen at 1, so a held-low line yields exactly one entry.
- Push: on the clk edge following the sampling tick of the final stop bit; m_valid is visible from that edge (registered, no combinational path from rx).
- FIFO:
  - Entry = {break, parity_err, frame_err, data[7:0]}; m_* outputs present the head entry.
  - A push while full with no pop in the same cycle drops the frame and pulses overrun.
  - A push while full with a pop in the same cycle succeeds.
  - Pop while empty is ignored. Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- rst mid-frame: FSM to IDLE, FIFO emptied, partial frame discarded.

Test Plan:
- div=27, length=8, no parity, 1 stop; send 0xA5 (bit period 432 clk), m_ready=1 -> one entry m_data=0xA5, all error flags 0; m_valid high 1 cycle before the pop.
- length=5, parity_en=1, parity_type=1; send 0x13 with correct parity bit 1, then with the parity bit flipped -> entries 0x13/perr=0 and 0x13/perr=1.
- stop2=1, second stop bit driven 0 -> frame_err=1, data intact; next frame 0x3C received clean.
- rx held low for 20 bit periods then released -> exactly one entry: data=0x00, m_break=1, frame_err=1; no further entries until the next valid start bit.
- 0.25-bit low glitch on idle line -> no entry, busy returns to 0 by mid-start bit; also a single-tick glitch at index 8 of a data bit is outvoted.
- m_ready=0, send DEPTH+1 frames -> first DEPTH frames retained in order, one overrun pulse; then push coincident with pop when full -> accepted; assert rst mid-frame -> m_valid=0, next frame received correctly.
